// File: rtl/issue_arb_rr.sv
// Round-robin issue arbiter: REQUESTERS buffers share one registered port, 1-cycle request-to-output latency.
// Backpressure: a stalled (out_valid & ~out_ready) or flushed output stage drops every req_ready bit.
module issue_arb_rr #(
   parameter  int DATA_WIDTH = 47,
   parameter  int REQUESTERS = 4,
   localparam int ID_W       = $clog2(REQUESTERS)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATA_WIDTH*REQUESTERS-1:0] req_data,
   input  logic [REQUESTERS-1:0]            req_valid,
   output logic [REQUESTERS-1:0]            req_ready,
   input  logic                             flush,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic [ID_W-1:0]                  out_id,
   output logic                             out_valid,
   input  logic                             out_ready
);

   logic [ID_W-1:0]       ptr;
   logic [DATA_WIDTH-1:0] slice [REQUESTERS];
   logic                  win_vld;
   logic [ID_W-1:0]       win_id;
   logic                  can_load;
   logic                  xfer;

   for (genvar g = 0; g < REQUESTERS; g++) begin : g_slice
      assign slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Wraps modulo REQUESTERS, which need not be a power of two.
   function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
      logic [ID_W:0] sum;
      sum = {1'b0, base} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(REQUESTERS)) begin
         sum = sum - (ID_W+1)'(REQUESTERS);
      end
      return sum[ID_W-1:0];
   endfunction

   // Scan from the farthest offset back to ptr so the closest valid buffer wins.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      for (int k = REQUESTERS-1; k >= 0; k--) begin
         if (req_valid[wrap_idx(ptr, k)]) begin
            win_vld = 1'b1;
            win_id  = wrap_idx(ptr, k);
         end
      end
   end

   assign can_load = (~out_valid | out_ready) & ~flush;
   assign xfer     = win_vld & can_load;

   always_comb begin
      req_ready = '0;
      if (xfer) begin
         req_ready[win_id] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= slice[win_id];
         out_id    <= win_id;
         ptr       <= (win_id == ID_W'(REQUESTERS-1)) ? '0 : win_id + 1'b1;
      end else if (flush || out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifndef SYNTHESIS
   a_ready_onehot : assert property (@(posedge clk) $onehot0(req_ready));
   a_stall_hold : assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data) && $stable(out_id)));
`endif

endmodule
